// File: rtl/rf_scoreboard_if.sv
// Decode/issue and writeback handshake seen by the register-file scoreboard.
// Decode drives the master side; the scoreboard answers with stall.
interface rf_scoreboard_if #(
  parameter int WSEL_W = 5
);
  logic              issue_valid;
  logic              issue_wen;
  logic [WSEL_W-1:0] issue_wsel;
  logic              issue_use1;
  logic [WSEL_W-1:0] issue_rsel1;
  logic              issue_use2;
  logic [WSEL_W-1:0] issue_rsel2;
  logic              stall;
  logic              wb_valid;
  logic [WSEL_W-1:0] wb_wsel;

  modport master (
    output issue_valid, issue_wen, issue_wsel, issue_use1, issue_rsel1,
           issue_use2, issue_rsel2, wb_valid, wb_wsel,
    input  stall
  );

  modport slave (
    input  issue_valid, issue_wen, issue_wsel, issue_use1, issue_rsel1,
           issue_use2, issue_rsel2, wb_valid, wb_wsel,
    output stall
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard with RAW/saturation stall and drain sequencer.
// Optional macro RF_SCOREBOARD_WB_BYPASS_EN lets a source read bypass a same-cycle writeback.
//
// state | meaning
// IDLE  | normal issue, hazards only
// DRAIN | issue held until every pending write has retired
// DONE  | drain complete, drain_done high until drain_req drops
module rf_scoreboard #(
  parameter int NREGS  = 32,
  parameter int WSEL_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  rf_scoreboard_if.slave    sb,
  input  logic              flush,
  input  logic              drain_req,
  output logic              drain_done,
  output logic [NREGS-1:0]  busy,
  output logic              err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pending     [NREGS];
  logic [CNT_W-1:0] pending_nxt [NREGS];
  logic             hz1, hz2, hz_sat, hazard, accept;
  logic             inc, dec, underflow, all_zero;

  always_comb begin
    hz1    = sb.issue_use1 && (sb.issue_rsel1 != '0) && (pending[sb.issue_rsel1] != '0);
    hz2    = sb.issue_use2 && (sb.issue_rsel2 != '0) && (pending[sb.issue_rsel2] != '0);
`ifdef RF_SCOREBOARD_WB_BYPASS_EN
    // The register file commits on the falling edge, so the last pending write is readable now.
    if ((pending[sb.issue_rsel1] == CNT_ONE) && sb.wb_valid &&
        (sb.wb_wsel == sb.issue_rsel1) && !flush)
      hz1 = 1'b0;
    if ((pending[sb.issue_rsel2] == CNT_ONE) && sb.wb_valid &&
        (sb.wb_wsel == sb.issue_rsel2) && !flush)
      hz2 = 1'b0;
`endif
    hz_sat = sb.issue_wen && (sb.issue_wsel != '0) && (pending[sb.issue_wsel] == CNT_MAX);
    hazard = hz1 || hz2 || hz_sat;
  end

  assign sb.stall   = sb.issue_valid && (hazard || (state != IDLE));
  assign accept     = sb.issue_valid && !sb.stall;
  assign drain_done = (state == DONE);

  always_comb begin
    inc            = 1'b0;
    dec            = 1'b0;
    all_zero       = 1'b1;
    pending_nxt[0] = '0;
    busy[0]        = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      inc            = accept && sb.issue_wen && (sb.issue_wsel == WSEL_W'(r));
      dec            = sb.wb_valid && (sb.wb_wsel == WSEL_W'(r)) && (pending[r] != '0);
      pending_nxt[r] = flush ? '0 : (pending[r] + CNT_W'(inc) - CNT_W'(dec));
      busy[r]        = (pending[r] != '0);
      if (pending[r] != '0)
        all_zero = 1'b0;
    end
    underflow = !flush && sb.wb_valid && (sb.wb_wsel != '0) && (pending[sb.wb_wsel] == '0);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < NREGS; r++)
        pending[r] <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++)
        pending[r] <= pending_nxt[r];
      if (underflow)
        err_underflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (drain_req) state_nxt = DRAIN;
      DRAIN:   if (all_zero)  state_nxt = DONE;
      DONE:    if (!drain_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed self-checking bench for rf_scoreboard; inputs change on the falling edge,
// combinational stall is checked 1 ns later, registered state right after each falling edge.
module tb_rf_scoreboard;

`ifdef RF_SCOREBOARD_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        CLK;
  logic        nRST;
  logic        flush;
  logic        drain_req;
  logic        drain_done;
  logic [31:0] busy;
  logic        err_underflow;
  int          n_chk;
  int          n_fail;

  rf_scoreboard_if #(.WSEL_W(5)) sb_if ();

  rf_scoreboard #(.NREGS(32), .WSEL_W(5), .CNT_W(2)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .sb            (sb_if),
    .flush         (flush),
    .drain_req     (drain_req),
    .drain_done    (drain_done),
    .busy          (busy),
    .err_underflow (err_underflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic v, input logic wen, input logic [4:0] ws,
                       input logic u1, input logic [4:0] r1,
                       input logic u2, input logic [4:0] r2);
    sb_if.issue_valid = v;
    sb_if.issue_wen   = wen;
    sb_if.issue_wsel  = ws;
    sb_if.issue_use1  = u1;
    sb_if.issue_rsel1 = r1;
    sb_if.issue_use2  = u2;
    sb_if.issue_rsel2 = r2;
  endtask

  task automatic wb(input logic v, input logic [4:0] ws);
    sb_if.wb_valid = v;
    sb_if.wb_wsel  = ws;
  endtask

  task automatic idle_in();
    issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    nRST = 1'b0; flush = 1'b0; drain_req = 1'b0;
    idle_in(); wb(1'b0, 5'd0);
    #12;
    chkv("rst_busy", busy, 32'h0);
    chk1("rst_drain_done", drain_done, 1'b0);
    chk1("rst_err", err_underflow, 1'b0);
    chk1("rst_stall", sb_if.stall, 1'b0);
    @(negedge CLK); nRST = 1'b1;

    // RAW hazard on r5
    @(negedge CLK); issue(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    #1 chk1("raw_first_issue", sb_if.stall, 1'b0);
    @(negedge CLK); chkv("raw_busy5", busy, 32'h20);
    issue(1'b1, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0);
    #1 chk1("raw_stall", sb_if.stall, 1'b1);
    @(negedge CLK); chkv("raw_busy5_held", busy, 32'h20); wb(1'b1, 5'd5);
    #1 chk1("raw_wb_same_cycle", sb_if.stall, !BYP);
    @(negedge CLK); wb(1'b0, 5'd0); chkv("raw_busy_clear", busy, 32'h0);
    #1 chk1("raw_release", sb_if.stall, 1'b0);

    // saturation on r7
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); issue(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
      #1 chk1("sat_fill", sb_if.stall, 1'b0);
    end
    @(negedge CLK); chkv("sat_busy7", busy, 32'h80);
    #1 chk1("sat_full_stall", sb_if.stall, 1'b1);
    @(negedge CLK); wb(1'b1, 5'd7);
    #1 chk1("sat_wb_same_cycle", sb_if.stall, 1'b1);
    @(negedge CLK); wb(1'b0, 5'd0);
    #1 chk1("sat_accept_after_wb", sb_if.stall, 1'b0);
    @(negedge CLK); idle_in(); wb(1'b1, 5'd7);
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK); wb(1'b0, 5'd0); chkv("sat_drained", busy, 32'h0);

    // issue and writeback to r3 in the same cycle, then r0 traffic
    issue(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    #1 chk1("r3_issue", sb_if.stall, 1'b0);
    @(negedge CLK); wb(1'b1, 5'd3);
    #1 chk1("r3_coincide_stall", sb_if.stall, 1'b0);
    @(negedge CLK); idle_in(); chkv("r3_coincide_busy", busy, 32'h8);
    @(negedge CLK); wb(1'b0, 5'd0); chkv("r3_retired", busy, 32'h0);
    issue(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0); wb(1'b1, 5'd0);
    #1 chk1("r0_issue_stall", sb_if.stall, 1'b0);
    @(negedge CLK); idle_in(); wb(1'b0, 5'd0);
    chkv("r0_busy", busy, 32'h0);
    chk1("r0_no_underflow", err_underflow, 1'b0);

    // underflow on r9
    wb(1'b1, 5'd9);
    @(negedge CLK); wb(1'b0, 5'd0);
    chk1("underflow_set", err_underflow, 1'b1);
    chkv("underflow_busy", busy, 32'h0);

    // drain with r4 pending twice
    issue(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge CLK);
    @(negedge CLK); idle_in(); chkv("drain_busy4", busy, 32'h10);
    drain_req = 1'b1;
    issue(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
    #1 chk1("drain_req_cycle_accept", sb_if.stall, 1'b0);
    @(negedge CLK); chk1("drain_not_done", drain_done, 1'b0); wb(1'b1, 5'd4);
    #1 chk1("drain_stall1", sb_if.stall, 1'b1);
    @(negedge CLK);
    #1 chk1("drain_stall2", sb_if.stall, 1'b1);
    @(negedge CLK); wb(1'b0, 5'd0);
    #1 chk1("drain_stall3", sb_if.stall, 1'b1);
    @(negedge CLK); chk1("drain_done_set", drain_done, 1'b1); chkv("drain_busy_empty", busy, 32'h0);
    #1 chk1("done_stall", sb_if.stall, 1'b1);
    @(negedge CLK); chk1("done_held", drain_done, 1'b1); drain_req = 1'b0;
    @(negedge CLK); chk1("done_cleared", drain_done, 1'b0);
    #1 chk1("idle_accept", sb_if.stall, 1'b0);

    // flush with r1/r2 pending, colliding issue and writeback squashed
    @(negedge CLK); issue(1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge CLK); issue(1'b1, 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge CLK); chkv("flush_busy_before", busy, 32'h6);
    issue(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0); wb(1'b1, 5'd1); flush = 1'b1;
    #1 chk1("flush_cycle_stall", sb_if.stall, 1'b0);
    @(negedge CLK); flush = 1'b0; idle_in(); wb(1'b0, 5'd0);
    chkv("flush_busy_after", busy, 32'h0);

    // writeback bypass on source 2
    issue(1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge CLK); chkv("byp_busy6", busy, 32'h40);
    issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6); wb(1'b1, 5'd6);
    #1 chk1("byp_stall", sb_if.stall, !BYP);
    @(negedge CLK); idle_in(); wb(1'b0, 5'd0); chkv("byp_busy_after", busy, 32'h0);
    issue(1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge CLK); issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6); wb(1'b1, 5'd6); flush = 1'b1;
    #1 chk1("byp_flush_stall", sb_if.stall, 1'b1);
    @(negedge CLK); flush = 1'b0; idle_in(); wb(1'b0, 5'd0);
    chkv("byp_flush_busy", busy, 32'h0);
    chk1("underflow_sticky", err_underflow, 1'b1);

    // reset in the middle of a drain
    issue(1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge CLK); idle_in(); drain_req = 1'b1;
    @(negedge CLK); drain_req = 1'b0; issue(1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
    #1 chk1("middrain_stall", sb_if.stall, 1'b1);
    #1 nRST = 1'b0;
    #1;
    chk1("middrain_rst_done", drain_done, 1'b0);
    chk1("middrain_rst_err", err_underflow, 1'b0);
    chkv("middrain_rst_busy", busy, 32'h0);
    chk1("middrain_rst_stall", sb_if.stall, 1'b0);
    @(negedge CLK); nRST = 1'b1;
    @(negedge CLK);
    #1 chk1("post_rst_accept", sb_if.stall, 1'b0);
    idle_in();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Tracks outstanding (issued, not yet written back) writes to each architectural register for the 32-entry register file.
- Stalls the decode/issue stage on read-after-write hazards and on saturated pending counters.
- Provides a drain sequence, used before halt or context flush, that holds issue until every pending write has retired.
- Sits beside the register file between decode and writeback. The register file writes on the falling clock edge.

Parameters:
NREGS, 32, number of architectural registers tracked; register 0 is never tracked.
WSEL_W, 5, register select width; equals log2(NREGS).
CNT_W, 2, width of each per-register pending-write counter; maximum count is 2**CNT_W-1.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
nRST  input  1  asynchronous reset, active low.
issue_valid  input  1  decode presents an instruction this cycle.
issue_wen  input  1  the instruction writes a register.
issue_wsel  input  WSEL_W  destination register.
issue_use1  input  1  the instruction reads rsel1.
issue_rsel1  input  WSEL_W  source register 1.
issue_use2  input  1  the instruction reads rsel2.
issue_rsel2  input  WSEL_W  source register 2.
stall  output  1  combinational; issue is not accepted this cycle.
wb_valid  input  1  writeback retires a write this cycle.
wb_wsel  input  WSEL_W  register being written back.
flush  input  1  squash all in-flight writes.
drain_req  input  1  pulse; request a drain.
drain_done  output  1  registered; high while in DONE.
busy  output  NREGS  bit r high when pending[r] != 0; bit 0 is always 0.
err_underflow  output  1  sticky; set by a writeback to a register with pending == 0.

Behaviour:
- Reset (asynchronous, nRST low):
  - all counters = 0, FSM = IDLE.
  - drain_done = 0, err_underflow = 0, busy = 0.
- hazard = (issue_use1 && rsel1 != 0 && pending[rsel1] != 0) || (same condition for rsel2) || (issue_wen && wsel != 0 && pending[wsel] == max).
- stall = issue_valid && (hazard || FSM != IDLE).
- Issue is accepted when issue_valid && !stall.
- Counter update per register r != 0, each rising edge:
  - inc = accepted && issue_wen && wsel == r.
  - dec = wb_valid && wb_wsel == r && pending[r] != 0.
  - pending[r] += inc - dec, so inc and dec in the same cycle leave the count unchanged.
  - Writes to register 0 are ignored by both issue and writeback.
- Underflow:
  - wb_valid to r != 0 with pending[r] == 0 sets err_underflow; the counter stays 0.
  - err_underflow clears only on reset.
- flush: all counters = 0 next edge. Flush overrides issue and writeback in the same cycle. The FSM is unaffected.
- FSM:
  - IDLE: drain_req -> DRAIN. Issue in the drain_req cycle is still evaluated with FSM == IDLE, so it may be accepted.
  - DRAIN: stall forced whenever issue_valid. Moves to DONE on the edge after all counters read 0 (sampled after that cycle's update).
  - DONE: drain_done = 1; stall forced. Leaves DONE when drain_req is low for a cycle -> IDLE.
  - drain_req while in DRAIN or DONE: ignored.
- Latency:
  - stall and hazard are same-cycle combinational.
  - busy reflects the counters (registered state).
- Reset mid-drain: returns to IDLE with drain_done = 0.

Optional Feature:
Macro: RF_SCOREBOARD_WB_BYPASS_EN.
- Defined: a source read does not hazard when pending[rsel] == 1 && wb_valid && wb_wsel == rsel, provided the register is not also flush-squashed. This is valid because the register file commits the value on the falling edge of the same cycle.
- Not defined: a source hazards whenever pending != 0; the instruction stalls one extra cycle after writeback.
- The saturation hazard and the counters are identical in both builds.

Test Plan:
- Reset, issue wen wsel=5, next cycle issue use1 rsel1=5 -> stall=1 and busy[5]=1. After wb 5 -> busy[5]=0 and stall=0 next cycle (without the macro).
- CNT_W=2: three issues to wsel=7 with no wb -> pending=3; fourth issue to r7 -> stall=1. One wb to r7 -> fourth issue accepted the following cycle.
- Issue wsel=3 together with wb r3 when pending[3]=1 -> count stays 1. Issue wsel=0 -> busy stays 0.
- wb to r9 with pending 0 -> err_underflow=1, persisting through later traffic until nRST.
- Pending r4=2, drain_req -> stall on every issue; after two wb to r4 -> drain_done=1. Drop drain_req -> IDLE and issue accepted.
- With the macro defined: pending[6]=1, wb r6 and issue use2 rsel2=6 in the same cycle -> stall=0. Flush with pending on r1/r2 -> busy=0 next edge.
